// File: rtl/fetch_pc.sv
// Program counter and fetch sequencer: selects the next pc from increment, LUT target
// or the return stack, and tracks IDLE/RUN/HALTED with sticky stack-error flags.
module fetch_pc #(
  parameter int unsigned D           = 10,
  parameter int unsigned STACK_DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         stall,
  input  logic         halt_req,
  input  logic         jump_en,
  input  logic         branch_en,
  input  logic         branch_cond,
  input  logic         call_en,
  input  logic         ret_en,
  input  logic [D-1:0] target,
  output logic [D-1:0] pc,
  output logic         running,
  output logic         done,
  output logic         stk_ovf,
  output logic         stk_unf
);

  localparam int unsigned CW = $clog2(STACK_DEPTH + 1);
  localparam int unsigned IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HALTED
  } state_t;

  state_t         state, state_nxt;
  logic [D-1:0]   pc_nxt;
  logic [CW-1:0]  count, count_nxt;
  logic           ovf_nxt, unf_nxt;
  logic           push;
  logic [D-1:0]   stack [STACK_DEPTH];
  logic [IW-1:0]  push_idx, top_idx;
  logic [D-1:0]   pc_inc;

  assign pc_inc   = pc + D'(1);
  assign push_idx = IW'(count);
  assign top_idx  = IW'(count - CW'(1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      pc      <= '0;
      count   <= '0;
      stk_ovf <= 1'b0;
      stk_unf <= 1'b0;
    end else begin
      state   <= state_nxt;
      pc      <= pc_nxt;
      count   <= count_nxt;
      stk_ovf <= ovf_nxt;
      stk_unf <= unf_nxt;
    end
  end

  // Stack storage needs no reset: entries at or above count are never read.
  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      stack[push_idx] <= pc_inc;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    count_nxt = count;
    ovf_nxt   = stk_ovf;
    unf_nxt   = stk_unf;
    push      = 1'b0;
    unique case (state)
      IDLE, HALTED: begin
        if (start) begin
          state_nxt = RUN;
          pc_nxt    = '0;
          count_nxt = '0;
          ovf_nxt   = 1'b0;
          unf_nxt   = 1'b0;
        end
      end
      RUN: begin
        if (!stall) begin
          if (halt_req) begin
            state_nxt = HALTED;
          end else if (ret_en) begin
            if (count != '0) begin
              pc_nxt    = stack[top_idx];
              count_nxt = count - CW'(1);
            end else begin
              unf_nxt   = 1'b1;
              state_nxt = HALTED;
            end
          end else if (call_en) begin
            if (count != CW'(STACK_DEPTH)) begin
              push      = 1'b1;
              pc_nxt    = target;
              count_nxt = count + CW'(1);
            end else begin
              ovf_nxt   = 1'b1;
              state_nxt = HALTED;
            end
          end else if (jump_en || (branch_en && branch_cond)) begin
            pc_nxt = target;
          end else begin
            pc_nxt = pc_inc;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    running = (state == RUN);
    done    = (state == HALTED);
  end

endmodule

// File: tb/tb_fetch_pc.sv
// Directed bench for fetch_pc: sequencing, branches, nested calls, stack errors,
// wrap-around, priority, stall and mid-sequence reset.
module tb_fetch_pc;

  localparam int unsigned D = 10;

  logic         clk = 1'b0;
  logic         rst_n, start, stall, halt_req, jump_en, branch_en, branch_cond, call_en, ret_en;
  logic [D-1:0] target;
  logic [D-1:0] pc;
  logic         running, done, stk_ovf, stk_unf;

  int unsigned checks = 0;
  int unsigned errors = 0;

  fetch_pc #(.D(D), .STACK_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stall(stall), .halt_req(halt_req),
    .jump_en(jump_en), .branch_en(branch_en), .branch_cond(branch_cond),
    .call_en(call_en), .ret_en(ret_en), .target(target),
    .pc(pc), .running(running), .done(done), .stk_ovf(stk_ovf), .stk_unf(stk_unf)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    start = 0; stall = 0; halt_req = 0; jump_en = 0; branch_en = 0;
    branch_cond = 0; call_en = 0; ret_en = 0; target = '0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Checks pc, running, done, stk_ovf, stk_unf together.
  task automatic check_all(input string tag, input int unsigned epc, input logic erun,
                           input logic edone, input logic eovf, input logic eunf);
    check({tag, ".pc"}, 32'(pc), 32'(epc));
    check({tag, ".running"}, 32'(running), 32'(erun));
    check({tag, ".done"}, 32'(done), 32'(edone));
    check({tag, ".ovf"}, 32'(stk_ovf), 32'(eovf));
    check({tag, ".unf"}, 32'(stk_unf), 32'(eunf));
  endtask

  initial begin
    clear_inputs();
    rst_n = 0;
    tick(); tick();
    check_all("reset", 0, 0, 0, 0, 0);
    rst_n = 1;

    jump_en = 1; target = 10'd300; tick();
    check_all("idle_ignores_jump", 0, 0, 0, 0, 0);
    clear_inputs();

    // 1. start and sequential increment
    start = 1; tick(); start = 0;
    check_all("start", 0, 1, 0, 0, 0);
    for (int i = 1; i <= 5; i++) begin
      tick();
      check($sformatf("seq%0d", i), 32'(pc), 32'(i));
    end
    check_all("seq_state", 5, 1, 0, 0, 0);

    // 2. jump and branches
    tick(); tick();
    check("at7", 32'(pc), 32'd7);
    jump_en = 1; target = 10'd80; tick(); clear_inputs();
    check("jump80", 32'(pc), 32'd80);
    branch_en = 1; branch_cond = 0; target = 10'd500; tick();
    check("branch_nt", 32'(pc), 32'd81);
    branch_cond = 1; target = 10'd121; tick(); clear_inputs();
    check("branch_t", 32'(pc), 32'd121);

    // 3. nested calls and returns
    jump_en = 1; target = 10'd10; tick(); clear_inputs();
    check("at10", 32'(pc), 32'd10);
    call_en = 1; target = 10'd55; tick();
    check("call55", 32'(pc), 32'd55);
    target = 10'd109; tick(); clear_inputs();
    check("call109", 32'(pc), 32'd109);
    ret_en = 1; tick();
    check("ret56", 32'(pc), 32'd56);
    tick();
    check("ret11", 32'(pc), 32'd11);
    tick(); clear_inputs();
    check_all("ret_underflow", 11, 0, 1, 0, 1);
    tick();
    check_all("halted_hold", 11, 0, 1, 0, 1);

    // 4. overflow on the fifth call
    start = 1; tick(); clear_inputs();
    check_all("restart", 0, 1, 0, 0, 0);
    call_en = 1;
    for (int i = 1; i <= 4; i++) begin
      target = 10'(i * 100);
      tick();
      check($sformatf("call%0d", i), 32'(pc), 32'(i * 100));
    end
    target = 10'd500; tick(); clear_inputs();
    check_all("overflow", 400, 0, 1, 1, 0);
    start = 1; tick(); clear_inputs();
    check_all("restart_ovf", 0, 1, 0, 0, 0);
    ret_en = 1; tick(); clear_inputs();
    check_all("stack_cleared", 0, 0, 1, 0, 1);

    // call+ret conflict: only the ret happens
    start = 1; tick(); clear_inputs();
    call_en = 1; target = 10'd50; tick();
    check("call50", 32'(pc), 32'd50);
    ret_en = 1; target = 10'd70; tick(); clear_inputs();
    check("call_ret_conflict", 32'(pc), 32'd1);
    ret_en = 1; tick(); clear_inputs();
    check_all("conflict_no_push", 1, 0, 1, 0, 1);

    // 5. wrap, stall, halt priority
    start = 1; tick(); clear_inputs();
    jump_en = 1; target = 10'd1023; tick(); clear_inputs();
    check("at1023", 32'(pc), 32'd1023);
    tick();
    check_all("wrap", 0, 1, 0, 0, 0);
    stall = 1; jump_en = 1; halt_req = 1; target = 10'd77; tick();
    check_all("stall_hold", 0, 1, 0, 0, 0);
    clear_inputs(); tick();
    check("after_stall", 32'(pc), 32'd1);
    halt_req = 1; jump_en = 1; target = 10'd95; tick(); clear_inputs();
    check_all("halt_prio", 1, 0, 1, 0, 0);
    jump_en = 1; target = 10'd95; tick(); clear_inputs();
    check_all("halted_ignores", 1, 0, 1, 0, 0);

    // 6. reset mid-call sequence
    start = 1; tick(); clear_inputs();
    call_en = 1; target = 10'd30; tick();
    target = 10'd40; tick();
    check("call40", 32'(pc), 32'd40);
    rst_n = 0; tick(); rst_n = 1; clear_inputs();
    check_all("mid_reset", 0, 0, 0, 0, 0);
    start = 1; tick(); clear_inputs();
    check_all("post_reset_start", 0, 1, 0, 0, 0);
    ret_en = 1; tick(); clear_inputs();
    check_all("post_reset_unf", 0, 0, 1, 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
